// File: rtl/kgp_stack_pkg.sv
// Shared constants and types for the KGP-RISC hardware stack controller.
// The stack holds DEPTH words of DW bits and is addressed with AW bits.
package kgp_stack_pkg;

   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned DW    = 32;

   typedef enum logic [2:0] {
      StIdle,
      StPush,
      StPop,
      StPopWait,
      StResp
   } state_e;

   typedef enum logic {
      OwnCore = 1'b0,
      OwnTrap = 1'b1
   } owner_e;

   // One-hot select of the owner's ack/err pair: bit 0 core, bit 1 trap.
   function automatic logic [1:0] owner_sel(owner_e o);
      return (o == OwnTrap) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Request/response handshake between one requester and the stack controller.
// The requester holds req/pop/wdata stable until it samples ack high.
interface stack_ctrl_if #(
   parameter int unsigned Dw = kgp_stack_pkg::DW
);

   logic          req;
   logic          pop;
   logic [Dw-1:0] wdata;
   logic          ack;
   logic          err;
   logic [Dw-1:0] rdata;

   modport master (
      output req,
      output pop,
      output wdata,
      input  ack,
      input  err,
      input  rdata
   );

   modport slave (
      input  req,
      input  pop,
      input  wdata,
      output ack,
      output err,
      output rdata
   );

endinterface

// File: rtl/stack_arb.sv
// Fixed-priority (trap over core) grant for the stack RAM port, plus the
// registers that hold the granted owner and push data for the transaction.
module stack_arb
   import kgp_stack_pkg::*;
#(
   parameter int unsigned Dw = DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          grant_en,
   input  logic          core_req,
   input  logic          core_pop,
   input  logic [Dw-1:0] core_wdata,
   input  logic          trap_req,
   input  logic          trap_pop,
   input  logic [Dw-1:0] trap_wdata,
   output logic          gnt,
   output owner_e        gnt_owner,
   output logic          gnt_pop,
   output owner_e        owner,
   output logic [Dw-1:0] wdata
);

   always_comb begin
      gnt       = grant_en & (trap_req | core_req);
      gnt_owner = trap_req ? OwnTrap : OwnCore;
      gnt_pop   = trap_req ? trap_pop : core_pop;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner <= OwnCore;
         wdata <= '0;
      end else if (gnt) begin
         owner <= gnt_owner;
         wdata <= (gnt_owner == OwnTrap) ? trap_wdata : core_wdata;
      end
   end

endmodule

// File: rtl/stack_ctrl.sv
// Stack pointer, full/empty status and RAM sequencing for the shared stack.
// Illegal pushes/pops complete with err and never touch the RAM.
module stack_ctrl
   import kgp_stack_pkg::*;
#(
   parameter int unsigned Aw = AW,
   parameter int unsigned Dw = DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   stack_ctrl_if.slave   core,
   stack_ctrl_if.slave   trap,
   output logic          mem_we,
   output logic          mem_re,
   output logic [Aw-1:0] mem_addr,
   output logic [Dw-1:0] mem_wdata,
   input  logic [Dw-1:0] mem_rdata,
   output logic [Aw:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [Aw:0]   CntFull = {1'b1, {Aw{1'b0}}};
   localparam logic [Aw:0]   CntOne  = {{Aw{1'b0}}, 1'b1};
   localparam logic [Aw-1:0] AddrOne = {{(Aw-1){1'b0}}, 1'b1};

   state_e        state_q;
   logic [Aw:0]   count_q;
   logic          err_q;
   logic [1:0]    ack_q;
   logic          we_q;
   logic          re_q;
   logic [Aw-1:0] addr_q;
   logic [Dw-1:0] core_rdata_q;
   logic [Dw-1:0] trap_rdata_q;

   logic          grant_en;
   logic          gnt;
   owner_e        gnt_owner;
   logic          gnt_pop;
   logic          gnt_err;
   owner_e        owner;
   logic [Dw-1:0] lat_wdata;

   assign full     = (count_q == CntFull);
   assign empty    = (count_q == '0);
   assign grant_en = (state_q == StIdle) & ~clear;
   assign gnt_err  = gnt_pop ? empty : full;

   stack_arb #(
      .Dw (Dw)
   ) u_arb (
      .clk        (clk),
      .reset      (reset),
      .grant_en   (grant_en),
      .core_req   (core.req),
      .core_pop   (core.pop),
      .core_wdata (core.wdata),
      .trap_req   (trap.req),
      .trap_pop   (trap.pop),
      .trap_wdata (trap.wdata),
      .gnt        (gnt),
      .gnt_owner  (gnt_owner),
      .gnt_pop    (gnt_pop),
      .owner      (owner),
      .wdata      (lat_wdata)
   );

   // RAM strobes and acks are registered on entry to the state that owns them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         count_q      <= '0;
         err_q        <= 1'b0;
         ack_q        <= '0;
         we_q         <= 1'b0;
         re_q         <= 1'b0;
         addr_q       <= '0;
         core_rdata_q <= '0;
         trap_rdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (clear) begin
                  count_q <= '0;
               end else if (gnt) begin
                  if (gnt_err) begin
                     err_q   <= 1'b1;
                     ack_q   <= owner_sel(gnt_owner);
                     state_q <= StResp;
                  end else if (gnt_pop) begin
                     re_q    <= 1'b1;
                     addr_q  <= count_q[Aw-1:0] - AddrOne;
                     state_q <= StPop;
                  end else begin
                     we_q    <= 1'b1;
                     addr_q  <= count_q[Aw-1:0];
                     state_q <= StPush;
                  end
               end
            end
            StPush: begin
               we_q    <= 1'b0;
               count_q <= count_q + CntOne;
               ack_q   <= owner_sel(owner);
               state_q <= StResp;
            end
            StPop: begin
               re_q    <= 1'b0;
               count_q <= count_q - CntOne;
               state_q <= StPopWait;
            end
            StPopWait: begin
               if (owner == OwnTrap) begin
                  trap_rdata_q <= mem_rdata;
               end else begin
                  core_rdata_q <= mem_rdata;
               end
               ack_q   <= owner_sel(owner);
               state_q <= StResp;
            end
            StResp: begin
               ack_q   <= '0;
               err_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_we    = we_q;
   assign mem_re    = re_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = lat_wdata;
   assign count     = count_q;

   assign core.ack   = ack_q[0];
   assign core.err   = ack_q[0] & err_q;
   assign core.rdata = core_rdata_q;
   assign trap.ack   = ack_q[1];
   assign trap.err   = ack_q[1] & err_q;
   assign trap.rdata = trap_rdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomised bench for stack_ctrl against a queue-based stack model, with a
// behavioural single-port RAM attached to the memory port.
module tb_stack_ctrl;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        mem_we;
   logic        mem_re;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [6:0]  count;
   logic        full;
   logic        empty;

   stack_ctrl_if core_if ();
   stack_ctrl_if trap_if ();

   stack_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .core      (core_if),
      .trap      (trap_if),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   logic [31:0] ram [64];

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model: the stack contents and each owner's last popped word.
   logic [31:0] model_q [$];
   logic [31:0] last_rd [2];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive_req(input bit trap, input bit req, input bit pop, input logic [31:0] wd);
      if (trap) begin
         trap_if.req = req; trap_if.pop = pop; trap_if.wdata = wd;
      end else begin
         core_if.req = req; core_if.pop = pop; core_if.wdata = wd;
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_count"}, 64'(count), 64'(model_q.size()));
      check({tag, "_full"}, 64'(full), 64'(model_q.size() == 64));
      check({tag, "_empty"}, 64'(empty), 64'(model_q.size() == 0));
   endtask

   // One complete transaction; returns with the controller back in IDLE.
   task automatic do_op(input bit trap, input bit pop, input logic [31:0] wd);
      bit          exp_err;
      int          exp_lat;
      logic [5:0]  exp_addr;
      int          lat;
      bit          got, we_seen, re_seen, both, stray, err_o;
      logic [5:0]  addr_s;
      logic [31:0] wd_s, rd_o;
      exp_err  = pop ? (model_q.size() == 0) : (model_q.size() == 64);
      exp_lat  = exp_err ? 1 : (pop ? 3 : 2);
      exp_addr = pop ? 6'(model_q.size() - 1) : 6'(model_q.size());
      lat = 0; got = 0; we_seen = 0; re_seen = 0; both = 0; stray = 0; err_o = 0;
      addr_s = '0; wd_s = '0;
      @(negedge clk);
      drive_req(trap, 1'b1, pop, wd);
      while (!got && lat < 12) begin
         @(posedge clk); #1;
         lat++;
         if (mem_we) begin we_seen = 1; addr_s = mem_addr; wd_s = mem_wdata; end
         if (mem_re) begin re_seen = 1; addr_s = mem_addr; end
         if (mem_we && mem_re) both = 1;
         if (trap ? core_if.ack : trap_if.ack) stray = 1;
         if (trap ? trap_if.ack : core_if.ack) begin
            got   = 1;
            err_o = trap ? trap_if.err : core_if.err;
         end
      end
      drive_req(trap, 1'b0, pop, wd);
      if (!exp_err && !pop) model_q.push_back(wd);
      if (!exp_err && pop) last_rd[trap] = model_q.pop_back();
      rd_o = trap ? trap_if.rdata : core_if.rdata;
      check("ack_seen", 64'(got), 64'd1);
      check("latency", 64'(lat), 64'(exp_lat));
      check("err", 64'(err_o), 64'(exp_err));
      check("mem_we_used", 64'(we_seen), 64'(!exp_err && !pop));
      check("mem_re_used", 64'(re_seen), 64'(!exp_err && pop));
      check("we_re_overlap", 64'(both), 64'd0);
      check("stray_ack", 64'(stray), 64'd0);
      if (!exp_err) check("mem_addr", 64'(addr_s), 64'(exp_addr));
      if (!exp_err && !pop) check("mem_wdata", 64'(wd_s), 64'(wd));
      check("rdata", 64'(rd_o), 64'(last_rd[trap]));
      check("rdata_other", 64'(trap ? core_if.rdata : trap_if.rdata), 64'(last_rd[!trap]));
      check_status("op");
      @(posedge clk); #1;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_q.delete();
      check("clear_count", 64'(count), 64'd0);
      check("clear_empty", 64'(empty), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_ack, c_ack;
      bit stray;
      reset = 1'b0;
      clear = 1'b0;
      drive_req(1'b0, 1'b0, 1'b0, '0);
      drive_req(1'b1, 1'b0, 1'b0, '0);
      last_rd[0] = '0;
      last_rd[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_ack", 64'({core_if.ack, trap_if.ack, core_if.err, trap_if.err}), 64'd0);
      check("rst_mem", 64'({mem_we, mem_re, mem_addr, mem_wdata}), 64'd0);
      check("rst_rdata", 64'({core_if.rdata, trap_if.rdata}), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Three pushes then three pops, then a pop on the empty stack.
      do_op(1'b0, 1'b0, 32'hA1);
      do_op(1'b0, 1'b0, 32'hA2);
      do_op(1'b0, 1'b0, 32'hA3);
      for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, '0);
      check("lifo_last", 64'(core_if.rdata), 64'hA1);
      do_op(1'b0, 1'b1, '0);

      // Fill to DEPTH, overflow once, then pop the top word.
      for (int i = 0; i < 64; i++) do_op(1'b0, 1'b0, 32'(i));
      check("full_at_depth", 64'(full), 64'd1);
      do_op(1'b0, 1'b0, 32'h1234);
      do_op(1'b0, 1'b1, '0);
      check("top_after_full", 64'(core_if.rdata), 64'h3F);
      do_clear();

      // Simultaneous requests: trap goes first, core on the next IDLE visit.
      t_ack = 0; c_ack = 0;
      @(negedge clk);
      drive_req(1'b1, 1'b1, 1'b0, 32'hDEAD);
      drive_req(1'b0, 1'b1, 1'b0, 32'hBEEF);
      for (int cyc = 1; cyc <= 16 && (t_ack == 0 || c_ack == 0); cyc++) begin
         @(posedge clk); #1;
         if (trap_if.ack && t_ack == 0) begin t_ack = cyc; trap_if.req = 1'b0; end
         if (core_if.ack && c_ack == 0) begin c_ack = cyc; core_if.req = 1'b0; end
      end
      @(posedge clk); #1;
      model_q.push_back(32'hDEAD);
      model_q.push_back(32'hBEEF);
      check("trap_first_ack", 64'(t_ack), 64'd2);
      check("core_second_ack", 64'(c_ack), 64'd5);
      check("ram0", 64'(ram[0]), 64'hDEAD);
      check("ram1", 64'(ram[1]), 64'hBEEF);
      check_status("arb");

      // Clear in IDLE at count 5, then clear during PUSH is ignored.
      for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 32'h500 + 32'(i));
      check("count_before_clear", 64'(count), 64'd5);
      do_clear();
      @(negedge clk);
      drive_req(1'b0, 1'b1, 1'b0, 32'h55);
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("clear_in_push_ack", 64'(core_if.ack), 64'd1);
      core_if.req = 1'b0;
      model_q.push_back(32'h55);
      check_status("clear_in_push");
      @(posedge clk); #1;

      // Randomised mix of owners and ops, with occasional flushes.
      for (int n = 0; n < 300; n++) begin
         int unsigned bias;
         bias = (model_q.size() > 48) ? 70 : ((model_q.size() < 4) ? 30 : 50);
         if ($urandom_range(0, 39) == 0) begin
            do_clear();
         end else begin
            do_op(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < bias), $urandom);
         end
      end

      // Reset asserted during POP_WAIT abandons the pop.
      do_op(1'b0, 1'b0, 32'h77);
      @(negedge clk);
      drive_req(1'b0, 1'b1, 1'b1, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      model_q.delete();
      last_rd[0] = '0;
      last_rd[1] = '0;
      check("rst_mid_count", 64'(count), 64'd0);
      check("rst_mid_ack", 64'({core_if.ack, core_if.err, trap_if.ack}), 64'd0);
      check("rst_mid_mem", 64'({mem_we, mem_re, mem_addr, mem_wdata}), 64'd0);
      check("rst_mid_rdata", 64'({core_if.rdata, trap_if.rdata}), 64'd0);
      core_if.req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      stray = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (core_if.ack || trap_if.ack) stray = 1;
      end
      check("rst_mid_no_ack", 64'(stray), 64'd0);
      check_status("after_rst");
      do_op(1'b1, 1'b1, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
